// File: rtl/data_mem_responder.sv
// Memory-side responder for the cpu data port: byte-addressed little-endian array with wait states.
// Optional statistics counters are built only when DMEM_STATS_EN is defined.
module data_mem_responder #(
    parameter int DEPTH_BYTES = 1024,
    parameter int WAIT_STATES = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      data_addr,
    input  logic [31:0]      data_in,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic [31:0]      data_out,
    output logic             mem_ready,
    output logic             mem_err,
    output logic             busy,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] err_count
);
    localparam int          AW        = (DEPTH_BYTES > 4) ? $clog2(DEPTH_BYTES) : 3;
    localparam logic [31:0] LAST_WORD = 32'(DEPTH_BYTES - 4);
    localparam logic [3:0]  WS        = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  wcnt;
    logic [AW-3:0] addr_q;
    logic [31:0] wdata_q;
    logic        write_q, err_q;

    logic [7:0]  memory [DEPTH_BYTES];

    logic          req, req_err, enter_resp;
    logic [AW-3:0] acc_idx;
    logic [31:0]   acc_data;
    logic          acc_write, acc_err;

    assign req     = mem_read | mem_write;
    assign req_err = (data_addr[1:0] != 2'b00) || (data_addr > LAST_WORD) || (mem_read && mem_write);

    // With zero wait states the access commits on the same edge that samples the request,
    // so the live inputs are used in IDLE and the latched copy everywhere else.
    assign acc_idx   = (state == S_IDLE) ? data_addr[AW-1:2] : addr_q;
    assign acc_data  = (state == S_IDLE) ? data_in           : wdata_q;
    assign acc_write = (state == S_IDLE) ? mem_write         : write_q;
    assign acc_err   = (state == S_IDLE) ? req_err           : err_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (req) state_next = (WS == 4'd0) ? S_RESP : S_WAIT;
            S_WAIT:  if (wcnt == 4'd1) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign enter_resp = (state_next == S_RESP) && (state != S_RESP);

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wcnt     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            data_out <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && req) begin
                addr_q  <= data_addr[AW-1:2];
                wdata_q <= data_in;
                write_q <= mem_write;
                err_q   <= req_err;
                wcnt    <= WS;
            end else if (state == S_WAIT) begin
                wcnt <= wcnt - 4'd1;
            end
            if (enter_resp) begin
                if (acc_err)
                    data_out <= '0;
                else if (!acc_write)
                    data_out <= {memory[{acc_idx, 2'd3}], memory[{acc_idx, 2'd2}],
                                 memory[{acc_idx, 2'd1}], memory[{acc_idx, 2'd0}]};
            end
        end
    end

    // NOTE: the array has no reset; contents survive reset, and only a committing store writes it.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && acc_write && !acc_err) begin
            memory[{acc_idx, 2'd0}] <= acc_data[7:0];
            memory[{acc_idx, 2'd1}] <= acc_data[15:8];
            memory[{acc_idx, 2'd2}] <= acc_data[23:16];
            memory[{acc_idx, 2'd3}] <= acc_data[31:24];
        end
    end

    assign mem_ready = (state == S_RESP);
    assign mem_err   = (state == S_RESP) && err_q;
    assign busy      = (state != S_IDLE);

`ifdef DMEM_STATS_EN
    logic [CNT_W-1:0] rd_q, wr_q, er_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q <= '0;
            wr_q <= '0;
            er_q <= '0;
        end else if (state == S_RESP) begin
            if (err_q) begin
                if (er_q != '1) er_q <= er_q + 1'b1;
            end else if (write_q) begin
                if (wr_q != '1) wr_q <= wr_q + 1'b1;
            end else begin
                if (rd_q != '1) rd_q <= rd_q + 1'b1;
            end
        end
    end

    assign rd_count  = rd_q;
    assign wr_count  = wr_q;
    assign err_count = er_q;
`else
    assign rd_count  = '0;
    assign wr_count  = '0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: four instances cover wait states 1/0/3 and a 2-bit counter build.
module tb_data_mem_responder;
`ifdef DMEM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst  [4];
    logic [31:0] addr [4];
    logic [31:0] din  [4];
    logic        rd   [4];
    logic        wr   [4];
    logic [31:0] dout [4];
    logic        rdy  [4];
    logic        err  [4];
    logic        bsy  [4];
    logic [15:0] rdc  [3];
    logic [15:0] wrc  [3];
    logic [15:0] erc  [3];
    logic [1:0]  s_rd, s_wr, s_er;

    int total  = 0;
    int failed = 0;
    int lat, bcyc;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_BYTES(1024), .WAIT_STATES(1), .CNT_W(16)) u0 (
        .clk(clk), .reset(rst[0]), .data_addr(addr[0]), .data_in(din[0]), .mem_read(rd[0]),
        .mem_write(wr[0]), .data_out(dout[0]), .mem_ready(rdy[0]), .mem_err(err[0]), .busy(bsy[0]),
        .rd_count(rdc[0]), .wr_count(wrc[0]), .err_count(erc[0]));
    data_mem_responder #(.DEPTH_BYTES(1024), .WAIT_STATES(0), .CNT_W(16)) u1 (
        .clk(clk), .reset(rst[1]), .data_addr(addr[1]), .data_in(din[1]), .mem_read(rd[1]),
        .mem_write(wr[1]), .data_out(dout[1]), .mem_ready(rdy[1]), .mem_err(err[1]), .busy(bsy[1]),
        .rd_count(rdc[1]), .wr_count(wrc[1]), .err_count(erc[1]));
    data_mem_responder #(.DEPTH_BYTES(1024), .WAIT_STATES(3), .CNT_W(16)) u2 (
        .clk(clk), .reset(rst[2]), .data_addr(addr[2]), .data_in(din[2]), .mem_read(rd[2]),
        .mem_write(wr[2]), .data_out(dout[2]), .mem_ready(rdy[2]), .mem_err(err[2]), .busy(bsy[2]),
        .rd_count(rdc[2]), .wr_count(wrc[2]), .err_count(erc[2]));
    data_mem_responder #(.DEPTH_BYTES(1024), .WAIT_STATES(0), .CNT_W(2)) u3 (
        .clk(clk), .reset(rst[3]), .data_addr(addr[3]), .data_in(din[3]), .mem_read(rd[3]),
        .mem_write(wr[3]), .data_out(dout[3]), .mem_ready(rdy[3]), .mem_err(err[3]), .busy(bsy[3]),
        .rd_count(s_rd), .wr_count(s_wr), .err_count(s_er));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives a request at a negedge and returns after the negedge where mem_ready is seen (or 40 cycles).
    task automatic req(input int u, input logic [31:0] a, input logic [31:0] d,
                       input logic r, input logic w, output int n, output int b);
        addr[u] = a; din[u] = d; rd[u] = r; wr[u] = w;
        n = 0; b = 0;
        do begin
            tick();
            n++;
            if (bsy[u]) b++;
        end while (!rdy[u] && n < 40);
    endtask

    task automatic release_req(input int u);
        rd[u] = 1'b0;
        wr[u] = 1'b0;
    endtask

    function automatic logic [31:0] word0(input int a);
        return {u0.memory[a+3], u0.memory[a+2], u0.memory[a+1], u0.memory[a]};
    endfunction

    function automatic logic [31:0] word2(input int a);
        return {u2.memory[a+3], u2.memory[a+2], u2.memory[a+1], u2.memory[a]};
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst[i] = 1'b1; addr[i] = '0; din[i] = '0; rd[i] = 1'b0; wr[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) rst[i] = 1'b0;

        // Reset state of every instance
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_dout%0d", i), dout[i], 32'h0);
            check($sformatf("rst_rdy%0d", i), {31'b0, rdy[i]}, 32'h0);
            check($sformatf("rst_err%0d", i), {31'b0, err[i]}, 32'h0);
            check($sformatf("rst_busy%0d", i), {31'b0, bsy[i]}, 32'h0);
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_rdc%0d", i), {16'b0, rdc[i]}, 32'h0);
            check($sformatf("rst_wrc%0d", i), {16'b0, wrc[i]}, 32'h0);
            check($sformatf("rst_erc%0d", i), {16'b0, erc[i]}, 32'h0);
        end

        // Test 1: store with one wait state
        req(0, 32'h8, 32'hDEADBEEF, 1'b0, 1'b1, lat, bcyc);
        check("t1_lat", lat, 2);
        check("t1_err", {31'b0, err[0]}, 32'h0);
        release_req(0);
        check("t1_m8", {24'b0, u0.memory[8]}, 32'hEF);
        check("t1_m9", {24'b0, u0.memory[9]}, 32'hBE);
        check("t1_m10", {24'b0, u0.memory[10]}, 32'hAD);
        check("t1_m11", {24'b0, u0.memory[11]}, 32'hDE);
        check("t1_dout", dout[0], 32'h0);
        tick();
        check("t1_pulse", {31'b0, rdy[0]}, 32'h0);
        check("t1_idle", {31'b0, bsy[0]}, 32'h0);

        // Test 2: load back
        req(0, 32'h8, 32'h0, 1'b1, 1'b0, lat, bcyc);
        check("t2_lat", lat, 2);
        check("t2_busy", bcyc, 2);
        check("t2_dout", dout[0], 32'hDEADBEEF);
        check("t2_err", {31'b0, err[0]}, 32'h0);
        release_req(0);
        tick();

        // Test 4: error cases on the one-wait-state instance
        req(0, 32'h6, 32'h0, 1'b1, 1'b0, lat, bcyc);
        check("t4a_lat", lat, 2);
        check("t4a_err", {31'b0, err[0]}, 32'h1);
        check("t4a_dout", dout[0], 32'h0);
        release_req(0);
        tick();
        req(0, 32'h8, 32'h0, 1'b1, 1'b0, lat, bcyc);
        check("t4b_dout", dout[0], 32'hDEADBEEF);
        release_req(0);
        tick();
        req(0, 32'd1024, 32'h0, 1'b1, 1'b0, lat, bcyc);
        check("t4c_err", {31'b0, err[0]}, 32'h1);
        check("t4c_dout", dout[0], 32'h0);
        release_req(0);
        tick();
        req(0, 32'h8, 32'h12345678, 1'b1, 1'b1, lat, bcyc);
        check("t4d_err", {31'b0, err[0]}, 32'h1);
        check("t4d_rdy", {31'b0, rdy[0]}, 32'h1);
        release_req(0);
        tick();
        check("t4d_word", word0(8), 32'hDEADBEEF);
        req(0, 32'd1020, 32'hCAFEF00D, 1'b0, 1'b1, lat, bcyc);
        check("t4e_err", {31'b0, err[0]}, 32'h0);
        release_req(0);
        tick();
        req(0, 32'd1020, 32'h0, 1'b1, 1'b0, lat, bcyc);
        check("t4f_dout", dout[0], 32'hCAFEF00D);
        release_req(0);
        tick();
        req(0, 32'hC, 32'h01020304, 1'b0, 1'b1, lat, bcyc);
        check("t4g_dout_kept", dout[0], 32'hCAFEF00D);
        release_req(0);
        tick();

        // Test 3: zero wait states, back-to-back traffic
        req(1, 32'h0, 32'h44332211, 1'b0, 1'b1, lat, bcyc);
        check("t3_st0_lat", lat, 1);
        req(1, 32'h4, 32'h88776655, 1'b0, 1'b1, lat, bcyc);
        check("t3_st1_lat", lat, 2);
        release_req(1);
        tick();
        req(1, 32'h0, 32'h0, 1'b1, 1'b0, lat, bcyc);
        check("t3_ld0_lat", lat, 1);
        check("t3_ld0", dout[1], 32'h44332211);
        req(1, 32'h4, 32'h0, 1'b1, 1'b0, lat, bcyc);
        check("t3_ld1_lat", lat, 2);
        check("t3_ld1", dout[1], 32'h88776655);
        release_req(1);
        check("t3_m0", {24'b0, u1.memory[0]}, 32'h11);
        check("t3_m7", {24'b0, u1.memory[7]}, 32'h88);
        tick();
        req(1, 32'h8, 32'h0000ABCD, 1'b0, 1'b1, lat, bcyc);
        release_req(1);
        tick();
        req(1, 32'h2, 32'h0, 1'b1, 1'b0, lat, bcyc);
        check("t3_err", {31'b0, err[1]}, 32'h1);
        release_req(1);
        tick();

        // Test 6 (first half): statistics on the 16-bit instance
        check("t6_wr", {16'b0, wrc[1]}, STATS ? 32'd3 : 32'd0);
        check("t6_rd", {16'b0, rdc[1]}, STATS ? 32'd2 : 32'd0);
        check("t6_er", {16'b0, erc[1]}, STATS ? 32'd1 : 32'd0);

        // Test 5: reset in the middle of a three-wait-state store
        req(2, 32'h10, 32'h0A0B0C0D, 1'b0, 1'b1, lat, bcyc);
        check("t5_lat", lat, 4);
        release_req(2);
        tick();
        req(2, 32'h10, 32'h0, 1'b1, 1'b0, lat, bcyc);
        check("t5_ld", dout[2], 32'h0A0B0C0D);
        release_req(2);
        tick();
        addr[2] = 32'h10; din[2] = 32'hFFFFFFFF; wr[2] = 1'b1;
        tick();
        check("t5_busy", {31'b0, bsy[2]}, 32'h1);
        tick();
        rst[2] = 1'b1;
        wr[2]  = 1'b0;
        tick();
        check("t5_dout", dout[2], 32'h0);
        check("t5_rdy", {31'b0, rdy[2]}, 32'h0);
        check("t5_err", {31'b0, err[2]}, 32'h0);
        check("t5_bsy", {31'b0, bsy[2]}, 32'h0);
        check("t5_word", word2(16), 32'h0A0B0C0D);
        rst[2] = 1'b0;
        repeat (6) tick();
        check("t5_word_late", word2(16), 32'h0A0B0C0D);
        check("t5_rdy_late", {31'b0, rdy[2]}, 32'h0);

        // Test 6 (second half): 2-bit counter saturation
        for (int k = 0; k < 5; k++) begin
            req(3, 32'(k * 4), 32'h0, 1'b1, 1'b0, lat, bcyc);
            release_req(3);
            tick();
        end
        check("t6_sat_rd", {30'b0, s_rd}, STATS ? 32'd3 : 32'd0);
        check("t6_sat_wr", {30'b0, s_wr}, 32'd0);
        check("t6_sat_er", {30'b0, s_er}, 32'd0);

        $display("%0d/%0d checks passed", total - failed, total);
        $finish;
    end
endmodule
